// File: rtl/cla_seq_add512_pkg.sv
// Shared definitions for the word-serial 512-bit adder: state encodings
// and default geometry (32-bit words, 16 words per operand).
package cla_seq_pkg;

   localparam int W_DEF     = 32;
   localparam int WORDS_DEF = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cla_seq_add512_if.sv
// Operand/result bus of the word-serial adder.
//
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both high. in_ready is high only in IDLE and in_valid is ignored
// elsewhere; out_valid stays high with sum_out/cout held until the edge where
// out_ready is high. Neither ready nor valid depends combinationally on the
// other side's signal. abort cancels an operation in RUN or DONE and blocks
// acceptance while in IDLE. state mirrors the controller state for debug.
interface cla_seq_add512_if #(
   parameter int W     = 32,
   parameter int WORDS = 16
);
   import cla_seq_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic               cin;
   logic [WORDS*W-1:0] a_in;
   logic [WORDS*W-1:0] b_in;
   logic               abort;
   logic               out_valid;
   logic               out_ready;
   logic [WORDS*W-1:0] sum_out;
   logic               cout;
   logic               busy;
   state_t             state;

   modport master (
      output in_valid, cin, a_in, b_in, abort, out_ready,
      input  in_ready, out_valid, sum_out, cout, busy, state
   );

   modport slave (
      input  in_valid, cin, a_in, b_in, abort, out_ready,
      output in_ready, out_valid, sum_out, cout, busy, state
   );

endinterface

// File: rtl/cla_seq_add512_cla32.sv
// 32-bit carry-lookahead adder: 4-bit groups with group generate/propagate
// and a lookahead chain over the eight groups.
module cla32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        ci,
   output logic [31:0] s,
   output logic        cout
);

   logic [31:0] g;
   logic [31:0] p;
   logic [31:0] c;
   logic [7:0]  gg;
   logic [7:0]  gp;
   logic [8:0]  gc;

   // Bit/group generate-propagate, group carries, then in-group carries.
   always_comb begin
      g  = a & b;
      p  = a ^ b;
      c  = '0;
      gg = '0;
      gp = '0;
      gc = '0;
      for (int k = 0; k < 8; k++) begin
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         gp[k] = &p[4*k +: 4];
      end
      gc[0] = ci;
      for (int k = 0; k < 8; k++) begin
         gc[k+1] = gg[k] | (gp[k] & gc[k]);
      end
      for (int k = 0; k < 8; k++) begin
         c[4*k] = gc[k];
         for (int i = 1; i < 4; i++) begin
            c[4*k+i] = g[4*k+i-1] | (p[4*k+i-1] & c[4*k+i-1]);
         end
      end
      s    = p ^ c;
      cout = gc[8];
   end

endmodule

// File: rtl/cla_seq_add512.sv
// Word-serial WORDS*W-bit adder: one CLA32 is reused once per cycle,
// least-significant word first, with the carry chained through carry_reg.
// W must equal the CLA32 width (32); 2**IDX_W must cover WORDS.
module cla_seq_add512
   import cla_seq_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int WORDS = WORDS_DEF,
   parameter int IDX_W = 4
) (
   input logic               clk,
   input logic               rst_n,
   cla_seq_add512_if.slave   bus
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   state_t             state;
   state_t             next_state;
   logic [IDX_W-1:0]   idx;
   logic               carry_reg;
   logic [WORDS*W-1:0] a_reg;
   logic [WORDS*W-1:0] b_reg;
   logic [WORDS*W-1:0] sum_reg;
   logic               cout_reg;

   logic               accept;
   logic               last_word;
   logic [W-1:0]       word_a;
   logic [W-1:0]       word_b;
   logic [W-1:0]       word_sum;
   logic               word_cout;

   // abort wins over in_valid, so nothing is taken on an aborting cycle
   assign accept    = (state == S_IDLE) && bus.in_valid && !bus.abort;
   assign last_word = (idx == LAST_IDX);

   assign word_a = a_reg[idx*W +: W];
   assign word_b = b_reg[idx*W +: W];

   cla32 u_cla (
      .a    (word_a),
      .b    (word_b),
      .ci   (carry_reg),
      .s    (word_sum),
      .cout (word_cout)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state: abort or consumption returns to IDLE
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (accept) next_state = S_RUN;
         end
         S_RUN: begin
            if (bus.abort)      next_state = S_IDLE;
            else if (last_word) next_state = S_DONE;
         end
         S_DONE: begin
            if (bus.abort || bus.out_ready) next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Outputs decoded from the state register only
   always_comb begin
      bus.in_ready  = (state == S_IDLE);
      bus.out_valid = (state == S_DONE);
      bus.busy      = (state == S_RUN) || (state == S_DONE);
      bus.state     = state;
      bus.sum_out   = sum_reg;
      bus.cout      = cout_reg;
   end

   // Datapath: latch operands, then write back one sum word per RUN cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         carry_reg <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  a_reg     <= bus.a_in;
                  b_reg     <= bus.b_in;
                  carry_reg <= bus.cin;
                  idx       <= '0;
                  sum_reg   <= '0;
               end
            end
            S_RUN: begin
               if (bus.abort) begin
                  // partial sum is left as-is
                  idx <= '0;
               end else begin
                  sum_reg[idx*W +: W] <= word_sum;
                  carry_reg           <= word_cout;
                  if (last_word) begin
                     cout_reg <= word_cout;
                     idx      <= '0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (bus.abort) idx <= '0;
            end
            default: idx <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_cla_seq_add512.sv
// Bench for cla_seq_add512: directed operands with hand-computed sums pushed
// into an expected queue; a monitor pops and compares on each consumed result.
module tb_cla_seq_add512;
   import cla_seq_pkg::*;

   localparam int N = 512;

   logic clk;
   logic rst_n;

   cla_seq_add512_if #(.W(32), .WORDS(16)) bus_if ();

   cla_seq_add512 #(.W(32), .WORDS(16), .IDX_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   logic [N:0]   exp_q[$];
   int           n_total;
   int           n_pass;
   logic         held_prev;
   logic [N-1:0] prev_sum;
   logic         prev_cout;
   int           hold_cnt;

   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         c;
   logic [N:0]   e;
   int           first_valid;
   logic         ready_low_all;
   logic         busy_all;
   logic         saw_valid;

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [N:0] act, input logic [N:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic wait_ready();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (bus_if.in_ready) ok = 1'b1;
      end
      if (!ok) chk("wait_ready_timeout", 513'(0), 513'(1));
   endtask

   // Present one operand set at a negedge, hold it across one edge.
   task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb,
                       input logic tc, input bit push, input logic [N:0] texp);
      wait_ready();
      bus_if.a_in     = ta;
      bus_if.b_in     = tb;
      bus_if.cin      = tc;
      bus_if.in_valid = 1'b1;
      if (push) exp_q.push_back(texp);
      @(posedge clk);
      #2;
      bus_if.in_valid = 1'b0;
   endtask

   // consumer back-pressure: 0-5 cycles of out_ready low per result
   initial begin
      bus_if.out_ready = 1'b0;
      hold_cnt = 0;
      forever begin
         @(posedge clk);
         #2;
         if (bus_if.out_valid && !bus_if.out_ready) begin
            if (hold_cnt == 0) bus_if.out_ready = 1'b1;
            else hold_cnt--;
         end else begin
            bus_if.out_ready = 1'b0;
            hold_cnt = $urandom_range(0, 5);
         end
      end
   end

   // monitor: result stability while stalled, and scoreboard compare
   always @(negedge clk) begin
      if (held_prev) begin
         chk("hold_sum", 513'(bus_if.sum_out), 513'(prev_sum));
         chk("hold_cout", 513'(bus_if.cout), 513'(prev_cout));
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 513'(1), 513'(0));
         end else begin
            chk("sum", 513'(bus_if.sum_out), 513'(exp_q[0][N-1:0]));
            chk("cout", 513'(bus_if.cout), 513'(exp_q[0][N]));
            exp_q.delete(0);
         end
      end
      held_prev <= bus_if.out_valid && !bus_if.out_ready && rst_n;
      prev_sum  <= bus_if.sum_out;
      prev_cout <= bus_if.cout;
   end

   initial begin
      n_total = 0;
      n_pass  = 0;
      held_prev = 1'b0;
      rst_n = 1'b0;
      bus_if.in_valid = 1'b0;
      bus_if.abort    = 1'b0;
      bus_if.cin      = 1'b0;
      bus_if.a_in     = '0;
      bus_if.b_in     = '0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 513'(bus_if.in_ready), 513'(1));
      chk("rst_out_valid", 513'(bus_if.out_valid), 513'(0));
      chk("rst_busy", 513'(bus_if.busy), 513'(0));
      chk("rst_sum", 513'(bus_if.sum_out), 513'(0));
      chk("rst_cout", 513'(bus_if.cout), 513'(0));

      // full carry ripple, latency and in_valid held with changing a_in
      wait_ready();
      bus_if.a_in     = {N{1'b1}};
      bus_if.b_in     = 512'd1;
      bus_if.cin      = 1'b0;
      bus_if.in_valid = 1'b1;
      exp_q.push_back({1'b1, {N{1'b0}}});
      @(posedge clk);
      first_valid   = 0;
      ready_low_all = 1'b1;
      busy_all      = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         #2 bus_if.a_in = {16{$urandom()}};
         @(negedge clk);
         if (bus_if.in_ready) ready_low_all = 1'b0;
         if (!bus_if.busy) busy_all = 1'b0;
         if (bus_if.out_valid && first_valid == 0) first_valid = k;
      end
      bus_if.in_valid = 1'b0;
      chk("latency", 513'(first_valid), 513'(16));
      chk("in_ready_low_run_done", 513'(ready_low_all), 513'(1));
      chk("busy_run_done", 513'(busy_all), 513'(1));

      // carry across a word boundary
      send(512'hFFFF_FFFF, 512'd1, 1'b0, 1, 513'h1_0000_0000);
      // carry-in only
      send(512'd0, 512'd0, 1'b1, 1, 513'd1);
      // max + max + 1 = all ones with carry out
      send({N{1'b1}}, {N{1'b1}}, 1'b1, 1, {(N+1){1'b1}});
      // mixed words
      send({16{32'h8000_0001}}, {16{32'h7FFF_FFFF}}, 1'b0, 1,
           {1'b1, {15{32'h0000_0001}}, 32'h0000_0000} );

      // abort in RUN at idx 7
      send(512'd123, 512'd456, 1'b0, 0, '0);
      repeat (7) @(posedge clk);
      #2 bus_if.abort = 1'b1;
      @(posedge clk);
      #2 bus_if.abort = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", 513'(bus_if.in_ready), 513'(1));
      chk("abort_state", 513'(bus_if.state), 513'(S_IDLE));
      saw_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus_if.out_valid) saw_valid = 1'b1;
      end
      chk("abort_no_valid", 513'(saw_valid), 513'(0));

      // abort in IDLE blocks acceptance
      bus_if.a_in = 512'd9;
      bus_if.b_in = 512'd9;
      bus_if.in_valid = 1'b1;
      bus_if.abort    = 1'b1;
      @(posedge clk);
      #2;
      bus_if.in_valid = 1'b0;
      bus_if.abort    = 1'b0;
      @(negedge clk);
      chk("idle_abort_not_busy", 513'(bus_if.busy), 513'(0));
      send(512'd5, 512'd7, 1'b1, 1, 513'd13);

      // reset in the middle of RUN
      send(512'd1000, 512'd1, 1'b0, 0, '0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("midrun_busy", 513'(bus_if.busy), 513'(1));
      rst_n = 1'b0;
      #1;
      chk("midrun_rst_valid", 513'(bus_if.out_valid), 513'(0));
      chk("midrun_rst_sum", 513'(bus_if.sum_out), 513'(0));
      chk("midrun_rst_cout", 513'(bus_if.cout), 513'(0));
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("midrun_rst_in_ready", 513'(bus_if.in_ready), 513'(1));
      send(512'd1, 512'd1, 1'b0, 1, 513'd2);

      // random operands against a full-width reference
      for (int t = 0; t < 20; t++) begin
         for (int w = 0; w < 16; w++) begin
            a[w*32 +: 32] = $urandom();
            b[w*32 +: 32] = $urandom();
         end
         c = 1'($urandom_range(0, 1));
         e = {1'b0, a} + {1'b0, b} + 513'(c);
         send(a, b, c, 1, e);
      end

      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      chk("drain", 513'(exp_q.size()), 513'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
